// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Responder end of the data-memory request interface. It accepts
//             one load/store at a time, inserts WAIT_CYCLES wait states, then
//             performs a byte/half/word/double access on a little-endian byte
//             array. The read data or an error is returned on a valid/ready
//             response channel.
//  Ports    : clk, reset (async, active-high)
//             req_valid/req_ready, req_write, req_size, req_addr, req_wdata
//             rsp_valid/rsp_ready, rsp_rdata, rsp_err
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_responder #(
   parameter int DEPTH_BYTES = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int c_ADDR_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
   // The counter only ever holds values up to WAIT_CYCLES-1.
   localparam int c_CNT_W  = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LOAD =
      c_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
   localparam logic [63:0] c_DEPTH = 64'(DEPTH_BYTES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t               r_state, w_state_next;
   logic [c_CNT_W-1:0]   r_cnt, w_cnt_next;
   logic                 r_write;
   logic [1:0]           r_size;
   logic [63:0]          r_addr;
   logic [63:0]          r_wdata;
   logic [7:0]           r_mem [DEPTH_BYTES];

   logic                 w_accept;
   logic                 w_enter_resp;
   logic                 w_eff_write;
   logic [1:0]           w_eff_size;
   logic [63:0]          w_eff_addr;
   logic [63:0]          w_eff_wdata;
   logic [3:0]           w_nbytes;
   logic [63:0]          w_limit;
   logic                 w_misalign;
   logic                 w_err;
   logic [c_ADDR_W-1:0]  w_base;
   logic [63:0]          w_load;

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign w_accept  = req_valid && req_ready;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_enter_resp = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (WAIT_CYCLES == 0) begin
                  w_state_next = S_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_next = S_WAIT;
                  w_cnt_next   = c_CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state_next = S_RESP;
               w_enter_resp = 1'b1;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // With zero wait states the access happens on the acceptance edge itself,
   // so the live request inputs are used instead of the captured copy.
   assign w_eff_write = (r_state == S_IDLE) ? req_write : r_write;
   assign w_eff_size  = (r_state == S_IDLE) ? req_size  : r_size;
   assign w_eff_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
   assign w_eff_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

   // ------------------------------------------------------ error detection
   assign w_nbytes = 4'd1 << w_eff_size;
   // Full 64-bit compare: high address bits can never alias into the array.
   assign w_limit  = c_DEPTH - {60'd0, w_nbytes - 4'd1};

   always_comb begin
      w_misalign = 1'b0;
      case (w_eff_size)
         2'd0: w_misalign = 1'b0;
         2'd1: w_misalign = w_eff_addr[0];
         2'd2: w_misalign = |w_eff_addr[1:0];
         2'd3: w_misalign = |w_eff_addr[2:0];
         default: w_misalign = 1'b0;
      endcase
   end

   assign w_err  = (w_eff_addr >= w_limit) || w_misalign;
   assign w_base = w_eff_addr[c_ADDR_W-1:0];

   // Little-endian assembly of the addressed bytes, zero-extended.
   always_comb begin
      w_load = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(w_nbytes)) begin
            w_load[8*i +: 8] = r_mem[w_base + c_ADDR_W'(i)];
         end
      end
   end

   // ------------------------------------------------ control / response regs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_write   <= 1'b0;
         r_size    <= 2'd0;
         r_addr    <= '0;
         r_wdata   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_write <= req_write;
            r_size  <= req_size;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         if (w_enter_resp) begin
            rsp_err   <= w_err;
            rsp_rdata <= (w_err || w_eff_write) ? '0 : w_load;
         end else if ((r_state == S_RESP) && rsp_ready) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
         end
      end
   end

   // Byte array: deliberately not reset. The reset term keeps an edge that
   // coincides with reset from committing a store.
   always_ff @(posedge clk) begin
      if (w_enter_resp && w_eff_write && !w_err && !reset) begin
         for (int i = 0; i < 8; i++) begin
            if (i < int'(w_nbytes)) begin
               r_mem[w_base + c_ADDR_W'(i)] <= w_eff_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Self-checking bench for data_mem_responder. Instance A uses the
//             default two wait states, instance B uses zero wait states.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // instance A (WAIT_CYCLES = 2)
   logic        a_req_valid = 1'b0, a_req_ready, a_req_write = 1'b0;
   logic [1:0]  a_req_size = 2'd0;
   logic [63:0] a_req_addr = '0, a_req_wdata = '0;
   logic        a_rsp_valid, a_rsp_ready = 1'b1, a_rsp_err;
   logic [63:0] a_rsp_rdata;
   // instance B (WAIT_CYCLES = 0)
   logic        b_req_valid = 1'b0, b_req_ready, b_req_write = 1'b0;
   logic [1:0]  b_req_size = 2'd0;
   logic [63:0] b_req_addr = '0, b_req_wdata = '0;
   logic        b_rsp_valid, b_rsp_ready = 1'b1, b_rsp_err;
   logic [63:0] b_rsp_rdata;

   data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(2)) u_dut_a (
      .clk(clk), .reset(reset),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
      .req_size(a_req_size), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) u_dut_b (
      .clk(clk), .reset(reset),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_size(b_req_size), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One transaction on instance A (sel=0) or B (sel=1) with rsp_ready high.
   // lat counts cycles from the first presentation cycle (cycle 0) to the
   // first cycle in which rsp_valid is seen.
   task automatic txn(input bit sel, input logic wr, input logic [1:0] sz,
                      input logic [63:0] addr, input logic [63:0] wd,
                      output logic [63:0] rd, output logic er, output int lat);
      @(negedge clk);
      lat = 0;
      if (!sel) begin
         a_req_valid = 1'b1; a_req_write = wr; a_req_size = sz;
         a_req_addr = addr;  a_req_wdata = wd;
      end else begin
         b_req_valid = 1'b1; b_req_write = wr; b_req_size = sz;
         b_req_addr = addr;  b_req_wdata = wd;
      end
      while (!(sel ? b_req_ready : a_req_ready) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 40);
      rd = sel ? b_rsp_rdata : a_rsp_rdata;
      er = sel ? b_rsp_err : a_rsp_err;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string       name;
      logic        wr;
      logic [1:0]  sz;
      logic [63:0] addr;
      logic [63:0] wd;
      logic [63:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      logic        er;
      int          lat;

      // Directed vectors for instance A (2 wait states => latency 3).
      vecs.push_back('{"st_d_40",    1'b1, 2'd3, 64'h40,  64'h1122334455667788, 64'h0, 1'b0});
      vecs.push_back('{"ld_b_40",    1'b0, 2'd0, 64'h40,  64'h0, 64'h88, 1'b0});
      vecs.push_back('{"ld_w_44",    1'b0, 2'd2, 64'h44,  64'h0, 64'h11223344, 1'b0});
      vecs.push_back('{"st_h_41",    1'b1, 2'd1, 64'h41,  64'hBEEF, 64'h0, 1'b1});
      vecs.push_back('{"ld_w_42",    1'b0, 2'd2, 64'h42,  64'h0, 64'h0, 1'b1});
      vecs.push_back('{"ld_d_40",    1'b0, 2'd3, 64'h40,  64'h0, 64'h1122334455667788, 1'b0});
      vecs.push_back('{"st_d_end",   1'b1, 2'd3, 64'(DEPTH-8), 64'h0102030405060708, 64'h0, 1'b0});
      vecs.push_back('{"ld_d_end",   1'b0, 2'd3, 64'(DEPTH-8), 64'h0, 64'h0102030405060708, 1'b0});
      vecs.push_back('{"ld_w_end",   1'b0, 2'd2, 64'(DEPTH-4), 64'h0, 64'h01020304, 1'b0});
      vecs.push_back('{"ld_h_end",   1'b0, 2'd1, 64'(DEPTH-2), 64'h0, 64'h0102, 1'b0});
      vecs.push_back('{"ld_b_last",  1'b0, 2'd0, 64'(DEPTH-1), 64'h0, 64'h01, 1'b0});
      vecs.push_back('{"ld_d_depth", 1'b0, 2'd3, 64'(DEPTH),   64'h0, 64'h0, 1'b1});
      vecs.push_back('{"ld_b_max",   1'b0, 2'd0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 1'b1});
      vecs.push_back('{"ld_b_alias", 1'b0, 2'd0, 64'h1_0000_0040, 64'h0, 64'h0, 1'b1});
      vecs.push_back('{"st_w_50",    1'b1, 2'd2, 64'h50,  64'hFFFFFFFF11111111, 64'h0, 1'b0});
      vecs.push_back('{"st_b_50",    1'b1, 2'd0, 64'h50,  64'hFFFFFFFFFFFFFF77, 64'h0, 1'b0});
      vecs.push_back('{"ld_w_50",    1'b0, 2'd2, 64'h50,  64'h0, 64'h11111177, 1'b0});
      vecs.push_back('{"ld_h_52",    1'b0, 2'd1, 64'h52,  64'h0, 64'h1111, 1'b0});

      // ---------------- reset state
      repeat (2) @(negedge clk);
      chk("reset_rsp_valid", 64'(a_rsp_valid), 64'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", 64'(a_req_ready), 64'h1);
      chk("idle_rsp_rdata", a_rsp_rdata, 64'h0);
      chk("idle_rsp_err",   64'(a_rsp_err), 64'h0);

      // ---------------- reset during WAIT drops the store
      txn(1'b0, 1'b1, 2'd0, 64'h10, 64'h00, rd, er, lat);   // prime byte 0x10
      @(negedge clk);
      a_req_valid = 1'b1; a_req_write = 1'b1; a_req_size = 2'd0;
      a_req_addr = 64'h10; a_req_wdata = 64'hAA;
      @(posedge clk);
      #1 a_req_valid = 1'b0;
      @(negedge clk);
      chk("wait_req_ready", 64'(a_req_ready), 64'h0);
      #1 reset = 1'b1;
      #1 chk("rst_rsp_valid0", 64'(a_rsp_valid), 64'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_rsp_valid", 64'(a_rsp_valid), 64'h0);
      end
      reset = 1'b0;
      #1 chk("post_rst_ready", 64'(a_req_ready), 64'h1);
      txn(1'b0, 1'b0, 2'd0, 64'h10, 64'h0, rd, er, lat);
      chk("rst_drop_rdata", rd, 64'h0);
      chk("rst_drop_err", 64'(er), 64'h0);

      // ---------------- table-driven vectors on instance A
      foreach (vecs[k]) begin
         txn(1'b0, vecs[k].wr, vecs[k].sz, vecs[k].addr, vecs[k].wd, rd, er, lat);
         chk({vecs[k].name, "_rdata"}, rd, vecs[k].exp_rd);
         chk({vecs[k].name, "_err"}, 64'(er), 64'(vecs[k].exp_err));
         chk({vecs[k].name, "_lat"}, 64'(lat), 64'd3);
      end

      // ---------------- response backpressure
      @(negedge clk);
      a_rsp_ready = 1'b0;
      a_req_valid = 1'b1; a_req_write = 1'b0; a_req_size = 2'd3; a_req_addr = 64'h40;
      @(posedge clk);
      #1 a_req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!a_rsp_valid && lat < 20);
      chk("bp_lat", 64'(lat), 64'd3);
      for (int i = 0; i < 5; i++) begin
         a_req_valid = (i % 2 == 0);
         a_req_write = 1'b1; a_req_size = 2'd2; a_req_addr = 64'h44;
         a_req_wdata = 64'hDEADBEEF;
         @(negedge clk);
         chk("bp_rsp_valid", 64'(a_rsp_valid), 64'h1);
         chk("bp_rsp_rdata", a_rsp_rdata, 64'h1122334455667788);
         chk("bp_rsp_err",   64'(a_rsp_err), 64'h0);
         chk("bp_req_ready", 64'(a_req_ready), 64'h0);
      end
      a_req_valid = 1'b0;
      a_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_cleared_rdata", a_rsp_rdata, 64'h0);
      chk("bp_idle_ready", 64'(a_req_ready), 64'h1);
      txn(1'b0, 1'b0, 2'd2, 64'h44, 64'h0, rd, er, lat);
      chk("bp_no_capture", rd, 64'h11223344);
      chk("bp_next_lat", 64'(lat), 64'd3);

      // ---------------- zero-wait instance, back-to-back loads
      txn(1'b1, 1'b1, 2'd3, 64'h8, 64'hCAFEF00D12345678, rd, er, lat);
      chk("b_st_lat", 64'(lat), 64'd1);
      chk("b_st_err", 64'(er), 64'h0);
      @(negedge clk);
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_size = 2'd3; b_req_addr = 64'h8;
      for (int i = 0; i < 8; i++) begin
         chk("b2b_req_ready", 64'(b_req_ready), 64'((i % 2) == 0));
         chk("b2b_rsp_valid", 64'(b_rsp_valid), 64'((i % 2) == 1));
         if (i % 2 == 1) chk("b2b_rsp_rdata", b_rsp_rdata, 64'hCAFEF00D12345678);
         @(negedge clk);
      end
      b_req_valid = 1'b0;
      txn(1'b1, 1'b0, 2'd1, 64'hF, 64'h0, rd, er, lat);
      chk("b_misalign_err", 64'(er), 64'h1);
      chk("b_misalign_lat", 64'(lat), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
